// File: rtl/input_conditioner.sv
// Conditions raw buttons and switches: 2-flop sync, per-input debounce,
// single-button press lock with hold-to-repeat, switch change strobe.
`ifndef BTN_SZ
`define BTN_SZ 4
`endif
`ifndef SW_SZ
`define SW_SZ 4
`endif

module input_conditioner #(
   parameter int BTN_W        = `BTN_SZ,
   parameter int SW_W         = `SW_SZ,
   parameter int DB_CYCLES    = 2_000_000,
   parameter int REPEAT_DELAY = 50_000_000,
   parameter int REPEAT_RATE  = 20_000_000,
   parameter int CNT_W        = 28
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [BTN_W-1:0] btn_i,
   input  logic [SW_W-1:0]  sw_i,
   output logic [BTN_W-1:0] btn_level_o,
   output logic [BTN_W-1:0] btn_pulse_o,
   output logic [SW_W-1:0]  sw_o,
   output logic             sw_chg_o
);

   localparam logic [CNT_W-1:0] DB_TERM    = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_TERM = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
   localparam logic [CNT_W-1:0] RATE_TERM  = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam bit               REPEAT_EN  = (REPEAT_DELAY > 0);

   logic [BTN_W-1:0]            btn_s1_q, btn_s2_q;
   logic [SW_W-1:0]             sw_s1_q, sw_s2_q;
   logic [BTN_W-1:0][CNT_W-1:0] btn_cnt_q, btn_cnt_d;
   logic [BTN_W-1:0]            btn_lvl_q, btn_lvl_d;
   logic [BTN_W-1:0]            pulse_q, pulse_d;
   logic [BTN_W-1:0]            active_q, active_d;
   logic [CNT_W-1:0]            rep_cnt_q, rep_cnt_d;
   logic                        rep_phase_q, rep_phase_d;
   logic                        rep_sup_q, rep_sup_d;
   logic [SW_W-1:0]             sw_q, sw_d;
   logic [CNT_W-1:0]            sw_cnt_q, sw_cnt_d;
   logic                        sw_chg_q, sw_chg_d;

   logic [BTN_W-1:0]            btn_rise;
   logic [BTN_W-1:0]            press_sel;
   logic                        sel_found;
   logic                        active_held;
   logic [CNT_W-1:0]            rep_term;

   // Per-bit debounce: the counter only runs while s2 disagrees with the stable level.
   always_comb begin
      btn_lvl_d = btn_lvl_q;
      btn_cnt_d = '0;
      for (int i = 0; i < BTN_W; i++) begin
         if (btn_s2_q[i] != btn_lvl_q[i]) begin
            if (btn_cnt_q[i] == DB_TERM) begin
               btn_lvl_d[i] = btn_s2_q[i];
            end else begin
               btn_cnt_d[i] = btn_cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   always_comb begin
      sw_d     = sw_q;
      sw_cnt_d = '0;
      sw_chg_d = 1'b0;
      if (sw_s2_q != sw_q) begin
         if (sw_cnt_q == DB_TERM) begin
            sw_d     = sw_s2_q;
            sw_chg_d = 1'b1;
         end else begin
            sw_cnt_d = sw_cnt_q + CNT_ONE;
         end
      end
   end

   assign btn_rise = btn_lvl_d & ~btn_lvl_q;

   always_comb begin
      press_sel = '0;
      sel_found = 1'b0;
      for (int i = 0; i < BTN_W; i++) begin
         if (btn_rise[i] && !sel_found) begin
            press_sel[i] = 1'b1;
            sel_found    = 1'b1;
         end
      end
   end

   // The lock is held while the active button's next level is still high;
   // a falling level frees the lock in that same cycle.
   assign active_held = |(active_q & btn_lvl_d);
   assign rep_term    = rep_phase_q ? RATE_TERM : DELAY_TERM;

   always_comb begin
      active_d    = '0;
      pulse_d     = '0;
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
      rep_sup_d   = 1'b0;
      if (active_held) begin
         active_d    = active_q;
         rep_phase_d = rep_phase_q;
         rep_sup_d   = rep_sup_q | sw_chg_d;
         if (REPEAT_EN && !rep_sup_d && rep_cnt_q == rep_term) begin
            pulse_d     = active_q;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b1;
         end else if (rep_cnt_q < rep_term) begin
            rep_cnt_d = rep_cnt_q + CNT_ONE;
         end else begin
            rep_cnt_d = rep_cnt_q;
         end
      end else if (sel_found) begin
         active_d  = press_sel;
         pulse_d   = press_sel;
         rep_sup_d = sw_chg_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         btn_s1_q    <= '0;
         btn_s2_q    <= '0;
         sw_s1_q     <= '0;
         sw_s2_q     <= '0;
         btn_cnt_q   <= '0;
         btn_lvl_q   <= '0;
         pulse_q     <= '0;
         active_q    <= '0;
         rep_cnt_q   <= '0;
         rep_phase_q <= 1'b0;
         rep_sup_q   <= 1'b0;
         sw_q        <= '0;
         sw_cnt_q    <= '0;
         sw_chg_q    <= 1'b0;
      end else begin
         btn_s1_q    <= btn_i;
         btn_s2_q    <= btn_s1_q;
         sw_s1_q     <= sw_i;
         sw_s2_q     <= sw_s1_q;
         btn_cnt_q   <= btn_cnt_d;
         btn_lvl_q   <= btn_lvl_d;
         pulse_q     <= pulse_d;
         active_q    <= active_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_phase_q <= rep_phase_d;
         rep_sup_q   <= rep_sup_d;
         sw_q        <= sw_d;
         sw_cnt_q    <= sw_cnt_d;
         sw_chg_q    <= sw_chg_d;
      end
   end

   assign btn_level_o = btn_lvl_q;
   assign btn_pulse_o = pulse_q;
   assign sw_o        = sw_q;
   assign sw_chg_o    = sw_chg_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a window/time based model.
module tb_input_conditioner;

   localparam int BTN_W = 3;
   localparam int SW_W  = 2;
   localparam int DB    = 4;
   localparam int DELAY = 10;
   localparam int RATE  = 5;
   localparam int MAXC  = 8192;

   logic             clk;
   logic             rst_i;
   logic [BTN_W-1:0] btn_i;
   logic [SW_W-1:0]  sw_i;
   logic [BTN_W-1:0] btn_level_o;
   logic [BTN_W-1:0] btn_pulse_o;
   logic [SW_W-1:0]  sw_o;
   logic             sw_chg_o;

   input_conditioner #(
      .BTN_W(BTN_W), .SW_W(SW_W), .DB_CYCLES(DB),
      .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE), .CNT_W(28)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .btn_i(btn_i), .sw_i(sw_i),
      .btn_level_o(btn_level_o), .btn_pulse_o(btn_pulse_o),
      .sw_o(sw_o), .sw_chg_o(sw_chg_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: inputs seen by the debouncers are raw samples delayed two edges
   logic [BTN_W-1:0] raw_btn [MAXC];
   logic [SW_W-1:0]  raw_sw  [MAXC];
   int               cyc      = 0;
   int               last_rst = -100;
   bit               model_ok = 1'b0;
   logic [BTN_W-1:0] m_lvl, old_lvl, v_btn, exp_pulse;
   logic [SW_W-1:0]  m_sw, v_sw;
   logic             exp_chg;
   int               m_active = -1;
   int               press_cyc = 0;
   bit               m_sup;
   bit               flip, sw_flip, held;
   int               t;

   function automatic logic [BTN_W-1:0] u_btn(input int j);
      if (j - 2 > last_rst) return raw_btn[j-2];
      return '0;
   endfunction

   function automatic logic [SW_W-1:0] u_sw(input int j);
      if (j - 2 > last_rst) return raw_sw[j-2];
      return '0;
   endfunction

   always @(posedge clk) begin
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      raw_btn[cyc] = btn_i;
      raw_sw[cyc]  = sw_i;
      if (rst_i) begin
         last_rst  = cyc;
         model_ok  = 1'b1;
         m_lvl     = '0;
         m_sw      = '0;
         m_active  = -1;
         m_sup     = 1'b0;
         exp_pulse = '0;
         exp_chg   = 1'b0;
      end else if (model_ok) begin
         old_lvl = m_lvl;
         // a level flips once the last DB synchronized samples all disagree with it
         for (int b = 0; b < BTN_W; b++) begin
            flip = 1'b1;
            for (int j = cyc - DB + 1; j <= cyc; j++) begin
               if (j <= last_rst) flip = 1'b0;
               else begin
                  v_btn = u_btn(j);
                  if (v_btn[b] == m_lvl[b]) flip = 1'b0;
               end
            end
            if (flip) m_lvl[b] = ~m_lvl[b];
         end
         sw_flip = 1'b1;
         for (int j = cyc - DB + 1; j <= cyc; j++) begin
            if (j <= last_rst) sw_flip = 1'b0;
            else begin
               v_sw = u_sw(j);
               if (v_sw == m_sw) sw_flip = 1'b0;
            end
         end
         exp_chg = sw_flip;
         if (sw_flip) m_sw = u_sw(cyc);
         exp_pulse = '0;
         held = (m_active >= 0) && m_lvl[m_active];
         if (held) begin
            if (exp_chg) m_sup = 1'b1;
            t = cyc - press_cyc;
            if (DELAY > 0 && !m_sup && t >= DELAY && ((t - DELAY) % RATE) == 0)
               exp_pulse[m_active] = 1'b1;
         end else begin
            m_active = -1;
            m_sup    = 1'b0;
            for (int b = 0; b < BTN_W; b++) begin
               if (m_active < 0 && m_lvl[b] && !old_lvl[b]) begin
                  m_active     = b;
                  press_cyc    = cyc;
                  exp_pulse[b] = 1'b1;
                  m_sup        = exp_chg;
               end
            end
         end
      end
      cyc++;
   end

   // compare process, away from the active edge
   always @(negedge clk) begin
      if (model_ok) begin
         check("level", 32'(btn_level_o), 32'(m_lvl));
         check("pulse", 32'(btn_pulse_o), 32'(exp_pulse));
         check("sw", 32'(sw_o), 32'(m_sw));
         check("sw_chg", 32'(sw_chg_o), 32'(exp_chg));
      end
   end

   // driver tasks
   int pc0, pc1, pc2;

   task automatic clr_pc();
      pc0 = 0; pc1 = 0; pc2 = 0;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         if (btn_pulse_o[0]) pc0++;
         if (btn_pulse_o[1]) pc1++;
         if (btn_pulse_o[2]) pc2++;
      end
   endtask

   int len;

   initial begin
      rst_i = 1'b1;
      btn_i = '0;
      sw_i  = '0;
      clr_pc();
      step(3);
      rst_i = 1'b0;
      check("rst_level", 32'(btn_level_o), 32'h0);
      check("rst_pulse", 32'(btn_pulse_o), 32'h0);
      check("rst_sw", 32'(sw_o), 32'h0);
      check("rst_chg", 32'(sw_chg_o), 32'h0);
      step(10);

      // press, hold-to-repeat, release
      clr_pc();
      btn_i = 3'b010;
      step(5);  check("s1_lvl_pre", 32'(btn_level_o), 32'b000);
      step(1);  check("s1_lvl_rise", 32'(btn_level_o), 32'b010);
                check("s1_press", 32'(btn_pulse_o), 32'b010);
      step(9);  check("s1_gap", 32'(btn_pulse_o), 32'b000);
      step(1);  check("s1_rep1", 32'(btn_pulse_o), 32'b010);
      step(5);  check("s1_rep2", 32'(btn_pulse_o), 32'b010);
      step(7);
      btn_i = 3'b000;
      step(3);  check("s1_rep4", 32'(btn_pulse_o), 32'b010);
      step(2);  check("s1_lvl_hold", 32'(btn_level_o), 32'b010);
      step(1);  check("s1_lvl_fall", 32'(btn_level_o), 32'b000);
      step(10); check("s1_pulse_cnt", 32'(pc1), 32'd5);

      // short glitch
      clr_pc();
      btn_i = 3'b001;
      step(3);
      btn_i = 3'b000;
      step(12);
      check("s2_pulse_cnt", 32'(pc0), 32'd0);
      check("s2_level", 32'(btn_level_o), 32'b000);

      // bouncing then stable
      clr_pc();
      for (int i = 0; i < 10; i++) begin
         btn_i = (((i / 2) % 2) == 0) ? 3'b100 : 3'b000;
         step(1);
      end
      check("s3_no_early", 32'(pc2), 32'd0);
      step(3);  check("s3_pre", 32'(btn_pulse_o), 32'b000);
      step(1);  check("s3_press", 32'(btn_pulse_o), 32'b100);
      step(4);
      btn_i = 3'b000;
      step(12);
      check("s3_pulse_cnt", 32'(pc2), 32'd1);

      // simultaneous presses, lowest index wins, loser never pulses
      clr_pc();
      btn_i = 3'b101;
      step(8);
      btn_i = 3'b100;
      step(30);
      check("s4_b0_cnt", 32'(pc0), 32'd1);
      check("s4_b2_cnt", 32'(pc2), 32'd0);
      check("s4_level", 32'(btn_level_o), 32'b100);
      btn_i = 3'b000;
      step(10);

      // switch change suppresses repeat of the held button
      clr_pc();
      btn_i = 3'b010;
      step(8);
      sw_i = 2'b01;
      step(5);  check("s5_sw_pre", 32'(sw_o), 32'b00);
                check("s5_chg_pre", 32'(sw_chg_o), 32'b0);
      step(1);  check("s5_sw", 32'(sw_o), 32'b01);
                check("s5_chg", 32'(sw_chg_o), 32'b1);
      step(1);  check("s5_chg_end", 32'(sw_chg_o), 32'b0);
      step(30); check("s5_pulse_cnt", 32'(pc1), 32'd1);
      btn_i = 3'b000;
      sw_i  = 2'b00;
      step(10);

      // reset mid-hold
      btn_i = 3'b010;
      step(12);
      rst_i = 1'b1;
      step(1);
      check("s6_rst_level", 32'(btn_level_o), 32'h0);
      check("s6_rst_pulse", 32'(btn_pulse_o), 32'h0);
      check("s6_rst_sw", 32'(sw_o), 32'h0);
      check("s6_rst_chg", 32'(sw_chg_o), 32'h0);
      rst_i = 1'b0;
      step(5);  check("s6_lvl_pre", 32'(btn_level_o), 32'b000);
      step(1);  check("s6_lvl", 32'(btn_level_o), 32'b010);
                check("s6_press", 32'(btn_pulse_o), 32'b010);
      btn_i = 3'b000;
      step(10);

      // randomized traffic, checked by the model every cycle
      for (int k = 0; k < 180; k++) begin
         if ($urandom_range(0, 2) == 0) btn_i = '0;
         else btn_i = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) sw_i = 2'($urandom_range(0, 3));
         len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 8));
         if ($urandom_range(0, 59) == 0) begin
            rst_i = 1'b1;
            step(1);
            rst_i = 1'b0;
         end
         step(len);
      end
      btn_i = '0;
      sw_i  = '0;
      step(12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
